// File: rtl/sdf_query_arbiter.sv
// Round-robin arbiter that shares one sceneQuery SDF evaluator between NUM_REQ ray-march lanes.
// One query is in flight at a time. obj_sel stays held until the muxed valid_out comes back.
// A watchdog aborts queries whose result never arrives.
// Optional build macro: SDF_ARB_STATS_EN adds query/timeout statistics counters.
module sdf_query_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned IDW            = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*96-1:0]  req_pos,
    input  logic [NUM_REQ-1:0]     req_obj,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   sq_valid_in,
    output logic [95:0]            sq_pos,
    output logic                   sq_obj_sel,
    input  logic [31:0]            sq_distance,
    input  logic                   sq_valid_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [31:0]            rsp_distance,
    output logic                   rsp_timeout,
    output logic                   busy
`ifdef SDF_ARB_STATS_EN
    ,
    output logic [31:0]            stat_queries,
    output logic [15:0]            stat_timeouts
`endif
);

    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WdogLast = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] LostDistance = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [95:0]      pos_q, pos_d;
    logic             obj_q, obj_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [31:0]      dist_q, dist_d;
    logic             timeout_q, timeout_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   scan_idx;

    // Round-robin pick: first pending lane after the last winner, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Next-state logic and the grant/issue strobes.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        pos_d       = pos_q;
        obj_d       = obj_q;
        wdog_d      = wdog_q;
        dist_d      = dist_q;
        timeout_d   = timeout_q;
        req_ready   = '0;
        sq_valid_in = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    pos_d    = req_pos[96*grant_idx +: 96];
                    obj_d    = req_obj[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = grant_idx;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                sq_valid_in = 1'b1;
                wdog_d      = '0;
                state_d     = StWait;
            end
            StWait: begin
                // A result arriving on the watchdog's last cycle still counts as valid.
                if (sq_valid_out) begin
                    dist_d    = sq_distance;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (wdog_q == WdogLast) begin
                    dist_d    = LostDistance;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A grant during reset would be lost, so the lane must not see it consumed.
        if (rst) begin
            req_ready = '0;
        end
    end

    // State and latched query/response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= IDW'(NUM_REQ - 1);
            id_q      <= '0;
            pos_q     <= '0;
            obj_q     <= 1'b0;
            wdog_q    <= '0;
            dist_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            pos_q     <= pos_d;
            obj_q     <= obj_d;
            wdog_q    <= wdog_d;
            dist_q    <= dist_d;
            timeout_q <= timeout_d;
        end
    end

    // pos/obj_sel come straight from the latch so sceneQuery keeps its mux steered.
    assign sq_pos       = pos_q;
    assign sq_obj_sel   = obj_q;
    assign rsp_valid    = (state_q == StResp);
    assign rsp_id       = id_q;
    assign rsp_distance = dist_q;
    assign rsp_timeout  = timeout_q;
    assign busy         = (state_q != StIdle);

`ifdef SDF_ARB_STATS_EN
    logic [31:0] stat_queries_q;
    logic [15:0] stat_timeouts_q;
    logic        issue_evt;
    logic        abort_evt;

    assign issue_evt = (state_q == StIssue);
    assign abort_evt = (state_q == StWait) && !sq_valid_out && (wdog_q == WdogLast);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_queries_q  <= '0;
            stat_timeouts_q <= '0;
        end else begin
            if (issue_evt && (stat_queries_q != '1)) begin
                stat_queries_q <= stat_queries_q + 1'b1;
            end
            if (abort_evt && (stat_timeouts_q != '1)) begin
                stat_timeouts_q <= stat_timeouts_q + 1'b1;
            end
        end
    end

    assign stat_queries  = stat_queries_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_sdf_query_arbiter.sv
// Self-checking bench for sdf_query_arbiter with a behavioural sceneQuery stand-in.
module tb_sdf_query_arbiter;

    localparam int NR  = 4;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*96-1:0]  req_pos;
    logic [NR-1:0]     req_obj;
    logic [NR-1:0]     req_ready;
    logic              sq_valid_in;
    logic [95:0]       sq_pos;
    logic              sq_obj_sel;
    logic [31:0]       sq_distance;
    logic              sq_valid_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_distance;
    logic              rsp_timeout;
    logic              busy;
`ifdef SDF_ARB_STATS_EN
    logic [31:0]       stat_queries;
    logic [15:0]       stat_timeouts;
`endif

    sdf_query_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TO),
        .IDW(IDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_pos(req_pos),
        .req_obj(req_obj),
        .req_ready(req_ready),
        .sq_valid_in(sq_valid_in),
        .sq_pos(sq_pos),
        .sq_obj_sel(sq_obj_sel),
        .sq_distance(sq_distance),
        .sq_valid_out(sq_valid_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_distance(rsp_distance),
        .rsp_timeout(rsp_timeout),
        .busy(busy)
`ifdef SDF_ARB_STATS_EN
        ,
        .stat_queries(stat_queries),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_grant;
    int exp_queries = 0;
    int exp_timeouts = 0;

    // sceneQuery stand-in: result L cycles after valid_in; L=0 means the result never comes.
    int lat_cfg = 1;
    bit inject = 1'b0;
    int sq_cnt = 0;

    function automatic logic [31:0] sdf_fn(input logic [95:0] p, input logic o);
        return p[95:64] - 32'h0100_0000 + {31'b0, o};
    endfunction

    initial begin : sq_model
        logic v;
        sq_valid_out = 1'b0;
        sq_distance  = '0;
        forever begin
            @(posedge clk);
            v = sq_valid_in;
            #2;
            if (v) sq_cnt = lat_cfg;
            else if (sq_cnt > 0) sq_cnt--;
            sq_valid_out = (sq_cnt == 1) || inject;
            sq_distance  = sdf_fn(sq_pos, sq_obj_sel);
        end
    end

    // Reference arbitration: first pending lane after the previous winner.
    function automatic int model_pick(input logic [NR-1:0] pend, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left just after a rising edge.
    task automatic do_query(input int lat, input bit keep, input int stall);
        int g, n;
        logic [95:0] epos;
        logic eobj;
        logic [31:0] edist;
        bit eto, held, stable;
        g = model_pick(req_valid, last_grant);
        lat_cfg = lat;
        @(negedge clk);
        chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
        if (g < 0) return;
        last_grant = g;
        epos  = req_pos[96*g +: 96];
        eobj  = req_obj[g];
        eto   = (lat == 0) || (lat > TO);
        edist = eto ? 32'h7FFF_FFFF : sdf_fn(epos, eobj);
        exp_queries++;
        if (eto) exp_timeouts++;
        @(posedge clk); #1;
        if (!keep) req_valid[g] = 1'b0;
        @(negedge clk);
        n = 1;
        chk("issue", {sq_valid_in, busy}, 2'b11);
        held = 1'b1;
        while (!rsp_valid && n < TO + 40) begin
            if (sq_pos !== epos || sq_obj_sel !== eobj || req_ready !== '0) held = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("held", held, 1);
        chk("latency", n, eto ? TO + 2 : lat + 2);
        chk("rsp", {rsp_id, rsp_distance, rsp_timeout}, {IDW'(g), edist, eto});
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_id !== IDW'(g) || rsp_distance !== edist ||
                rsp_timeout !== eto || req_ready !== '0) stable = 1'b0;
        end
        if (stall > 0) chk("stall", stable, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_noready", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin : guard
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        int g, lat;
        bit quiet;
        rst = 1'b1;
        req_valid = '1;
        req_pos = '0;
        req_obj = '0;
        rsp_ready = 1'b0;
        last_grant = NR - 1;

        // Reset state, with all lanes requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {req_ready, sq_valid_in, rsp_valid, rsp_timeout, busy}, 0);
        chk("rst_data", {rsp_distance, rsp_id, sq_pos, sq_obj_sel}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // Single lane 0 query, pos=(0,0,2.0), L=1.
        req_pos[95:0] = {32'h0200_0000, 32'h0, 32'h0};
        req_obj[0] = 1'b0;
        req_valid = 4'b0001;
        do_query(1, 0, 0);

        // All lanes held valid: strict rotation.
        for (int l = 0; l < NR; l++) req_pos[96*l +: 96] = {$urandom, $urandom, $urandom};
        req_valid = '1;
        for (int i = 0; i < 8; i++) do_query(1 + i % 3, 1, 0);
        req_valid = '0;

        // Lane 2 box frame, L=3.
        req_obj[2] = 1'b1;
        req_valid = 4'b0100;
        do_query(3, 0, 0);

        // Lost result, then a late result landing while the timeout response is stalled.
        req_valid = 4'b0010;
        do_query(0, 0, 0);
        req_valid = 4'b0010;
        do_query(TO + 3, 0, 5);
        @(posedge clk); #1;
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        chk("late_drop", quiet, 1);
        @(posedge clk); #1;

        // Backpressure with lanes 1 and 3 pending; lane 3 must win right after release.
        req_valid = 4'b1000;
        do_query(1, 0, 0);
        req_valid = 4'b1010;
        do_query(2, 1, 10);
        do_query(2, 0, 0);
        req_valid = '0;

`ifdef SDF_ARB_STATS_EN
        chk("stat_q", stat_queries, exp_queries);
        chk("stat_t", stat_timeouts, exp_timeouts);
`endif

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            for (int l = 0; l < NR; l++) begin
                if (!req_valid[l] && $urandom_range(1) == 1) begin
                    req_valid[l] = 1'b1;
                    req_pos[96*l +: 96] = {$urandom, $urandom, $urandom};
                    req_obj[l] = 1'($urandom_range(1));
                end
            end
            if (req_valid == '0) begin
                g = int'($urandom_range(NR - 1));
                req_valid[g] = 1'b1;
                req_pos[96*g +: 96] = {$urandom, $urandom, $urandom};
                req_obj[g] = 1'($urandom_range(1));
            end
            lat = int'($urandom_range(9));
            do_query(lat, 1'($urandom_range(1)), int'($urandom_range(3)));
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during WAIT; the result that follows must be ignored.
        lat_cfg = 6;
        req_pos[96*2 +: 96] = {32'h0300_0000, 32'h0, 32'h0};
        req_valid = 4'b0100;
        g = model_pick(req_valid, last_grant);
        @(negedge clk);
        chk("rst_mid_grant", req_ready, 1 << g);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        chk("rst_mid_quiet", quiet, 1);
        last_grant = NR - 1;
        exp_queries = 0;
        exp_timeouts = 0;
`ifdef SDF_ARB_STATS_EN
        chk("stat_rst", {stat_queries, stat_timeouts}, 0);
`endif
        @(posedge clk); #1;
        req_valid = 4'b1001;
        do_query(2, 0, 0);
        req_valid = '0;
`ifdef SDF_ARB_STATS_EN
        chk("stat_q_end", stat_queries, exp_queries);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
